// File: rtl/led_rate_ctrl_if.sv
// Rate-control bundle: raw button in; debounced level, rate index, half-period and reload strobe out.
interface led_rate_ctrl_if #(
    parameter int CNT_W = 26
);
    logic             btn;
    logic             btn_db;
    logic [1:0]       mode;
    logic [CNT_W-1:0] half_period;
    logic             load;

    modport master (
        input  btn,
        output btn_db,
        output mode,
        output half_period,
        output load
    );

    modport slave (
        output btn,
        input  btn_db,
        input  mode,
        input  half_period,
        input  load
    );
endinterface

// File: rtl/led_rate_ctrl.sv
// Debounced pushbutton stepping through four blink half-periods, with a one-cycle reload strobe.
// Optional auto-repeat while the button is held: define RATE_AUTOREPEAT_EN.
module led_rate_ctrl #(
    parameter int CNT_W           = 26,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PERIOD0         = 25_000_000,
    parameter int PERIOD1         = 12_500_000,
    parameter int PERIOD2         = 6_250_000,
    parameter int PERIOD3         = 50_000_000,
    parameter int HOLD_CYCLES     = 25_000_000
) (
    input  logic            clk,
    input  logic            rst,
    led_rate_ctrl_if.master bus
);
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_ADV, S_WAIT} state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             sync1_r;
    logic             sync2_r;
    logic             btn_s;
    logic [DB_W-1:0]  db_cnt_r;
    logic             btn_db_r;
    logic             btn_db_d_r;
    logic             press_s;
    logic             hold_done_s;
    logic [1:0]       mode_r;
    logic [CNT_W-1:0] half_period_r;
    logic             load_r;

    function automatic logic [CNT_W-1:0] period_of(input logic [1:0] m);
        case (m)
            2'd0:    period_of = CNT_W'(PERIOD0);
            2'd1:    period_of = CNT_W'(PERIOD1);
            2'd2:    period_of = CNT_W'(PERIOD2);
            2'd3:    period_of = CNT_W'(PERIOD3);
            default: period_of = CNT_W'(PERIOD0);
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= bus.btn;
            sync2_r <= sync1_r;
        end
    end

    assign btn_s = sync2_r;

    // Debounce: accept a new level only after it differs stably for DEBOUNCE_CYCLES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt_r   <= {DB_W{1'b0}};
            btn_db_r   <= 1'b0;
            btn_db_d_r <= 1'b0;
        end else begin
            btn_db_d_r <= btn_db_r;
            if (btn_s == btn_db_r) begin
                db_cnt_r <= {DB_W{1'b0}};
            end else if (db_cnt_r == DB_LAST) begin
                btn_db_r <= btn_s;
                db_cnt_r <= {DB_W{1'b0}};
            end else begin
                db_cnt_r <= db_cnt_r + DB_W'(1);
            end
        end
    end

    assign press_s = btn_db_r & ~btn_db_d_r;

`ifdef RATE_AUTOREPEAT_EN
    localparam int HOLD_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    // The ADV cycle plus HOLD_CYCLES-1 WAIT cycles make up one repeat interval
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 2);

    logic [HOLD_W-1:0] hold_cnt_r;

    assign hold_done_s = (state_r == S_WAIT) && btn_db_r && (hold_cnt_r == HOLD_LAST);

    // Hold timer: runs while held in S_WAIT, clears on release or on each repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end else if ((state_r == S_WAIT) && btn_db_r && !hold_done_s) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
        end else begin
            hold_cnt_r <= {HOLD_W{1'b0}};
        end
    end
`else
    assign hold_done_s = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_INIT: state_next_s = S_IDLE;
            S_IDLE: begin
                if (press_s) begin
                    state_next_s = S_ADV;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ADV:  state_next_s = S_WAIT;
            S_WAIT: begin
                if (!btn_db_r) begin
                    state_next_s = S_IDLE;
                end else if (hold_done_s) begin
                    state_next_s = S_ADV;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            default: state_next_s = S_INIT;
        endcase
    end

    // Registered outputs: new mode/half-period appear together with the load strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r        <= 2'd0;
            half_period_r <= CNT_W'(PERIOD0);
            load_r        <= 1'b0;
        end else begin
            case (state_r)
                S_INIT: begin
                    mode_r        <= 2'd0;
                    half_period_r <= CNT_W'(PERIOD0);
                    load_r        <= 1'b1;
                end
                S_ADV: begin
                    mode_r        <= mode_r + 2'd1;
                    half_period_r <= period_of(mode_r + 2'd1);
                    load_r        <= 1'b1;
                end
                default: begin
                    load_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_db      = btn_db_r;
    assign bus.mode        = mode_r;
    assign bus.half_period = half_period_r;
    assign bus.load        = load_r;
endmodule

// File: tb/tb_led_rate_ctrl.sv
// Scoreboard bench for led_rate_ctrl: expected load events are queued as stimulus is applied.
module tb_led_rate_ctrl;
    localparam int CNT_W = 26;
    localparam int DB    = 4;
    localparam int HOLD  = 16;

    typedef struct packed {
        logic [1:0]       mode;
        logic [CNT_W-1:0] hp;
    } exp_t;

    logic clk;
    logic rst;
    int   err_cnt;
    int   chk_cnt;
    int   load_cnt;
    int   base;
    logic [1:0] mode_m;
    exp_t sb_q[$];
    exp_t mon_e;

    led_rate_ctrl_if #(.CNT_W(CNT_W)) bus ();

    led_rate_ctrl #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DB),
        .PERIOD0(10), .PERIOD1(20), .PERIOD2(30), .PERIOD3(40),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] period_m(input logic [1:0] m);
        case (m)
            2'd0:    period_m = CNT_W'(10);
            2'd1:    period_m = CNT_W'(20);
            2'd2:    period_m = CNT_W'(30);
            default: period_m = CNT_W'(40);
        endcase
    endfunction

    task automatic expect_adv();
        exp_t e;
        mode_m = mode_m + 2'd1;
        e.mode = mode_m;
        e.hp   = period_m(mode_m);
        sb_q.push_back(e);
    endtask

    task automatic expect_init();
        exp_t e;
        mode_m = 2'd0;
        e.mode = 2'd0;
        e.hp   = CNT_W'(10);
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: every load cycle must match the oldest expected event
    always @(negedge clk) begin
        if (!rst && bus.load) begin
            load_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected_load", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("load_mode", 32'(bus.mode), 32'(mon_e.mode));
                check("load_hp", 32'(bus.half_period), 32'(mon_e.hp));
            end
        end
    end

    task automatic clean_press(input int hold);
        expect_adv();
        bus.btn = 1'b1;
        tick(hold);
        bus.btn = 1'b0;
        tick(10);
    endtask

    initial begin
        err_cnt  = 0;
        chk_cnt  = 0;
        load_cnt = 0;
        mode_m   = 2'd0;
        rst      = 1'b1;
        bus.btn  = 1'b0;
        tick(3);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_hp", 32'(bus.half_period), 32'd10);
        check("rst_load", 32'(bus.load), 32'd0);
        check("rst_db", 32'(bus.btn_db), 32'd0);

        // Reset release: a single INIT load with PERIOD0
        expect_init();
        rst = 1'b0;
        tick(1);
        check("init_load", 32'(bus.load), 32'd1);
        tick(1);
        check("init_load_off", 32'(bus.load), 32'd0);
        tick(5);
        check("init_pending", 32'(sb_q.size()), 32'd0);
        check("init_loads", 32'(load_cnt), 32'd1);

        // Glitch shorter than the debounce window is rejected
        base = load_cnt;
        bus.btn = 1'b1;
        tick(3);
        bus.btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("glitch_db", 32'(bus.btn_db), 32'd0);
            tick(1);
        end
        check("glitch_mode", 32'(bus.mode), 32'd0);
        check("glitch_loads", 32'(load_cnt - base), 32'd0);

        // Cycle-accurate first press: btn_db at 6, load at 8
        base = load_cnt;
        expect_adv();
        bus.btn = 1'b1;
        tick(5);
        check("db_early", 32'(bus.btn_db), 32'd0);
        tick(1);
        check("db_rise", 32'(bus.btn_db), 32'd1);
        tick(1);
        check("load_early", 32'(bus.load), 32'd0);
        tick(1);
        check("load_at_8", 32'(bus.load), 32'd1);
        check("mode_at_8", 32'(bus.mode), 32'd1);
        tick(1);
        check("load_after", 32'(bus.load), 32'd0);
        tick(4);
        bus.btn = 1'b0;
        tick(10);
        check("press1_loads", 32'(load_cnt - base), 32'd1);
        check("press1_db_low", 32'(bus.btn_db), 32'd0);

        // Remaining presses wrap through 2,3,0 and back to 1
        base = load_cnt;
        for (int i = 0; i < 4; i++) begin
            clean_press(8 + i);
        end
        check("wrap_loads", 32'(load_cnt - base), 32'd4);
        check("wrap_mode", 32'(bus.mode), 32'd1);
        check("wrap_hp", 32'(bus.half_period), 32'd20);
        check("wrap_pending", 32'(sb_q.size()), 32'd0);

        // Reset in the ADV cycle discards the advance; held button re-debounces after reset
        bus.btn = 1'b1;
        tick(7);
        rst = 1'b1;
        #1;
        check("midrst_mode", 32'(bus.mode), 32'd0);
        check("midrst_load", 32'(bus.load), 32'd0);
        check("midrst_hp", 32'(bus.half_period), 32'd10);
        check("midrst_db", 32'(bus.btn_db), 32'd0);
        tick(2);
        base = load_cnt;
        expect_init();
        expect_adv();
        rst = 1'b0;
        tick(12);
        bus.btn = 1'b0;
        tick(10);
        check("midrst_loads", 32'(load_cnt - base), 32'd2);
        check("midrst_mode_after", 32'(bus.mode), 32'd1);

        // Long hold: one advance, or one per repeat interval with auto-repeat
        base = load_cnt;
        expect_adv();
`ifdef RATE_AUTOREPEAT_EN
        expect_adv();
        expect_adv();
        expect_adv();
`endif
        bus.btn = 1'b1;
        tick(60);
        bus.btn = 1'b0;
        tick(12);
`ifdef RATE_AUTOREPEAT_EN
        check("hold_loads", 32'(load_cnt - base), 32'd4);
`else
        check("hold_loads", 32'(load_cnt - base), 32'd1);
`endif
        check("final_pending", 32'(sb_q.size()), 32'd0);
        check("final_load_off", 32'(bus.load), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
